// File: rtl/csa_pkg.sv
// csa_pkg: shared defaults for the carry-select adder slice.
//   DEFAULT_WIDTH : operand / sum width in bits
//   DEFAULT_BLOCK : bits per carry-select segment
//   NUM_BLOCKS    : segment count at the default sizing
package csa_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_BLOCK = 4;
  localparam int NUM_BLOCKS    = DEFAULT_WIDTH / DEFAULT_BLOCK;
endpackage

// File: rtl/rca_block.sv
// rca_block: BLOCK-bit ripple-carry adder built from full-adder equations.
//   x, y : BLOCK-bit addends
//   ci   : carry into bit 0
//   s    : BLOCK-bit sum
//   co   : carry out of bit BLOCK-1
module rca_block
  import csa_pkg::*;
#(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[BLOCK];

endmodule

// File: rtl/carry_select_adder.sv
// carry_select_adder: registered WIDTH-bit carry-select adder, 1-cycle latency.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears sum/cout
//   a, b : WIDTH-bit unsigned operands
//   cin  : carry into bit 0
//   sum  : registered (a + b + cin) mod 2^WIDTH
//   cout : registered carry out of bit WIDTH-1
// WIDTH must be a multiple of BLOCK.
module carry_select_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSEG = WIDTH / BLOCK;

  // Per-segment candidates: index 0 = computed with carry-in 0, 1 = carry-in 1.
  logic [BLOCK-1:0] s0  [NSEG];
  logic [BLOCK-1:0] s1  [NSEG];
  logic             co0 [NSEG];
  logic             co1 [NSEG];

  logic [WIDTH-1:0] sum_next;
  logic             carry;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    if (k == 0) begin : g_first
      rca_block #(.BLOCK(BLOCK)) u_rca (
        .x  (a[BLOCK-1:0]),
        .y  (b[BLOCK-1:0]),
        .ci (cin),
        .s  (s0[0]),
        .co (co0[0])
      );
      // Segment 0 has a single adder fed by cin; mirroring it into the
      // carry-in-1 slot keeps the select loop below uniform.
      assign s1[0]  = s0[0];
      assign co1[0] = co0[0];
    end else begin : g_sel
      rca_block #(.BLOCK(BLOCK)) u_rca0 (
        .x  (a[k*BLOCK +: BLOCK]),
        .y  (b[k*BLOCK +: BLOCK]),
        .ci (1'b0),
        .s  (s0[k]),
        .co (co0[k])
      );
      rca_block #(.BLOCK(BLOCK)) u_rca1 (
        .x  (a[k*BLOCK +: BLOCK]),
        .y  (b[k*BLOCK +: BLOCK]),
        .ci (1'b1),
        .s  (s1[k]),
        .co (co1[k])
      );
    end
  end

  // Select chain: each segment's carry-out steers the next segment's mux.
  always_comb begin
    sum_next = '0;
    carry    = cin;
    for (int k = 0; k < NSEG; k++) begin
      if (carry) begin
        sum_next[k*BLOCK +: BLOCK] = s1[k];
        carry                      = co1[k];
      end else begin
        sum_next[k*BLOCK +: BLOCK] = s0[k];
        carry                      = co0[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= carry;
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
module tb_carry_select_adder;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  logic        armed = 1'b0;
  logic [32:0] exp_q;

  carry_select_adder #(.WIDTH(WIDTH), .BLOCK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 33-bit arithmetic sum of whatever was present at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q <= 33'd0;
    else     exp_q <= {1'b0, a} + {1'b0, b} + {32'd0, cin};
  end

  // Continuous compare against the reference, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ({cout, sum} !== exp_q) begin
        errors++;
        $display("FAIL model_cmp t=%0t got cout=%0b sum=%08h want cout=%0b sum=%08h",
                 $time, cout, sum, exp_q[32], exp_q[31:0]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] want_sum, input logic want_cout);
    checks++;
    if (sum !== want_sum || cout !== want_cout) begin
      errors++;
      $display("FAIL %s got cout=%0b sum=%08h want cout=%0b sum=%08h",
               name, cout, sum, want_cout, want_sum);
    end
  endtask

  // Drive one vector after an edge, then check the result after the following edge.
  task automatic vec(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                     input logic [31:0] want_sum, input logic want_cout, input string name);
    a = va; b = vb; cin = vc;
    @(posedge clk); #1;
    check_lit(name, want_sum, want_cout);
  endtask

  initial begin
    rst = 1'b1;
    a = 32'hDEADBEEF; b = 32'h12345678; cin = 1'b1;
    #2 armed = 1'b1;

    // Outputs held at zero through several edges while reset is high.
    repeat (3) @(posedge clk);
    #1 check_lit("reset_hold", 32'h0, 1'b0);

    // First edge after release loads the current operands.
    a = 32'd5; b = 32'd7; cin = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_lit("post_reset_load", 32'd13, 1'b0);

    @(posedge clk); #1;
    vec(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, "full_carry_chain");
    vec(32'h0000000F, 32'h00000000, 1'b1, 32'h00000010, 1'b0, "seg_boundary");
    vec(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, "no_carry_pattern");
    vec(32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, "msb_overflow");
    vec(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, "all_ones_cin");
    vec(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, "zero");
    vec(32'h0FFFFFFF, 32'h00000000, 1'b1, 32'h10000000, 1'b0, "ripple_to_top_seg");

    // Latency: result holds until the next edge even if inputs change mid-cycle.
    a = 32'h00000100; b = 32'h00000200; cin = 1'b0;
    @(posedge clk); #1;
    a = 32'h11111111; b = 32'h11111111;
    #2 check_lit("hold_until_edge", 32'h00000300, 1'b0);
    @(posedge clk); #1;
    check_lit("next_edge_update", 32'h22222222, 1'b0);

    // Random pairs, each held two cycles, first with cin=0 then cin=1.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 40; i++) begin
        a = $urandom; b = $urandom; cin = pass[0];
        repeat (2) @(posedge clk);
        #1;
      end
    end

    // Asynchronous reset asserted between edges clears outputs at once.
    a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1;
    @(posedge clk); #1;
    check_lit("pre_async_rst", 32'h00000000, 1'b1);
    a = 32'h00000001; b = 32'h00000001; cin = 1'b0;
    #2 rst = 1'b1;
    #1 check_lit("async_rst_clear", 32'h0, 1'b0);
    @(posedge clk); #1;
    check_lit("rst_discard_pending", 32'h0, 1'b0);
    a = 32'h00000030; b = 32'h0000000C; cin = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_lit("rst_release_load", 32'h0000003C, 1'b0);

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carry_select_adder.md
CARRY_SELECT_ADDER -- requirements
Module: carry_select_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter BLOCK, default 4, giving the bits per carry-select segment; WIDTH SHALL be a multiple of BLOCK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, unsigned.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-008 The block SHALL have port sum, output, WIDTH bits: registered result bits [WIDTH-1:0].
REQ-009 The block SHALL have port cout, output, 1 bit: registered carry out of bit WIDTH-1.

Function
REQ-010 {cout,sum} SHALL equal a + b + cin, computed at WIDTH+1 bits with no truncation.
REQ-011 Segment 0 (bits BLOCK-1:0) SHALL be a single ripple-carry adder fed directly by cin.
REQ-012 Each segment k>0 SHALL compute two ripple-carry results in parallel, one with carry-in 0 and one with carry-in 1.
REQ-013 Each segment k>0 SHALL select its sum and carry-out with a 2:1 mux steered by the carry-out of segment k-1.
REQ-014 The carry-out of the last segment SHALL be cout.
REQ-015 The adder datapath SHALL be purely combinational from a, b and cin to the output registers.
REQ-016 a, b and cin SHALL be sampled on every rising clk edge; there is no enable and no handshake.
REQ-017 Latency SHALL be exactly 1 cycle: values present before edge N appear on sum/cout after edge N and hold until edge N+1.
REQ-018 Throughput SHALL be one new result per cycle.
REQ-019 Overflow SHALL wrap modulo 2^WIDTH in sum, with the overflow bit reported on cout.
REQ-020 X/Z on inputs is outside the contract; no X-propagation handling SHALL be added.

Reset
REQ-021 While rst=1, sum SHALL be 0 and cout SHALL be 0, independent of clk.
REQ-022 Assertion of rst mid-operation SHALL clear the outputs immediately and discard the pending result.
REQ-023 On the first rising edge after rst deasserts, the outputs SHALL capture the current a + b + cin.

Structure
REQ-024 Package csa_pkg SHALL hold the default WIDTH (32) and BLOCK (4) constants and the derived NUM_BLOCKS = WIDTH/BLOCK.
REQ-025 A sub-module rca_block SHALL implement a BLOCK-bit ripple-carry adder built from full-adder equations (inputs x, y, ci; outputs s, co).
REQ-026 carry_select_adder SHALL instantiate rca_block once for segment 0 and twice for every other segment.
REQ-027 The segment muxes and the output register SHALL reside in carry_select_adder.

Verification
REQ-028 Assert rst, then deassert -> sum=0x00000000 and cout=0 during reset; first post-reset edge loads the current sum.
REQ-029 a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 1 edge, sum=0x00000000, cout=1 (full carry chain through all segments).
REQ-030 a=0x0000000F, b=0x00000000, cin=1 -> sum=0x00000010, cout=0 (segment-boundary select).
REQ-031 a=0x12345678, b=0x87654321, cin=0 -> sum=0x99999999, cout=0; then a=0x80000000, b=0x80000000, cin=1 -> sum=0x00000001, cout=1.
REQ-032 40 random a/b pairs, one every 2 cycles, with cin=0, then repeated with cin=1 -> each registered result equals the 33-bit reference a+b+cin one cycle after sampling.
REQ-033 Assert rst between two sampling edges -> outputs drop to 0 asynchronously, before the next clk edge.
